cpu_run_controller: RTL and testbench

- Multi-cycle sequencing FSM for the CPU core.
- Steps each instruction through fetch, decode, execute, memory and writeback, and generates enables for PC, IR, ALU, register file and memory ports.
- Handles the HALT instruction and resumes on a rising edge of the external continue input.
- Maintains cycle and retired-instruction counters for the debug bus, and traps memory handshakes that never complete into a sticky FAULT state.

---
 rtl/cpu_run_controller.sv | 160 ++++++++++++++++
 tb/tb_cpu_run_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Multi-cycle run controller: sequences FETCH/DECODE/EXEC/MEM/WB, handles HALT/continue,
// traps stalled memory handshakes into a sticky FAULT, and keeps debug counters.
module cpu_run_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             continue_in,
    input  logic             is_halt,
    input  logic             is_mem,
    input  logic             is_store,
    input  logic             writes_reg,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_en,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               halt_wb_q, halt_wb_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instr_q, instr_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic               pulse_q, pulse_d;
    logic               wait_last;

    // Two-flop synchronizer followed by a registered rising-edge detector
    always_comb begin
        sync1_d = continue_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    assign wait_last = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        halt_wb_d = halt_wb_q;
        instr_d   = instr_q;
        cycle_d   = cycle_q + CNT_W'(1);
        imem_req  = 1'b0;
        ir_en     = 1'b0;
        alu_en    = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                alu_en  = 1'b1;
                state_d = is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (wait_last) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                // A resumed HALT only advances the PC sequentially
                pc_en     = 1'b1;
                rf_we     = writes_reg & ~halt_wb_q;
                pc_sel    = branch_taken & ~halt_wb_q;
                halt_wb_d = 1'b0;
                instr_d   = instr_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (pulse_q) begin
                    state_d   = S_WB;
                    halt_wb_d = 1'b1;
                end
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            wait_q    <= '0;
            halt_wb_q <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halt_wb_q <= halt_wb_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pulse_q   <= pulse_d;
        end
    end

    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed instruction sequences plus a cycle-level
// instruction-phase model compared on every falling edge.
module tb_cpu_run_controller;

    localparam int unsigned T  = 16;
    localparam int unsigned CW = 32;

    localparam int P_BOOT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_MEM = 4, P_WB = 5, P_HALT = 6, P_FAULT = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cont = 1'b0;
    logic is_halt = 1'b0, is_mem = 1'b0, is_store = 1'b0, writes_reg = 1'b0;
    logic branch_taken = 1'b0, imem_ready = 1'b1, dmem_ready = 1'b1;
    logic imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault;
    logic [2:0] state;
    logic [CW-1:0] cycle_count, instr_count;

    int total = 0;
    int bad = 0;
    int seq1 [6] = '{0, 1, 2, 3, 5, 1};

    always #5 clk = ~clk;

    cpu_run_controller #(.TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .continue_in(cont), .is_halt(is_halt), .is_mem(is_mem),
        .is_store(is_store), .writes_reg(writes_reg), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_en(ir_en),
        .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .pc_en(pc_en),
        .pc_sel(pc_sel), .halted(halted), .fault(fault), .state(state),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Phase model: which step of the instruction we are in, how long the current
    // memory request has gone unanswered, and recent continue samples.
    int            m_ph = P_BOOT;
    int            m_stall = 0;
    bit            m_resumed = 1'b0;
    logic [3:0]    m_hist = '0;
    logic [CW-1:0] m_cyc = '0, m_ins = '0;
    logic [12:0]   ev, av;

    always @(negedge clk) begin
        int nxt;
        bit rdy;
        if (!rst_n) begin
            m_ph = P_BOOT; m_stall = 0; m_resumed = 1'b0; m_hist = '0; m_cyc = '0; m_ins = '0;
        end
        ev = '0;
        ev[12:10] = 3'(m_ph);
        case (m_ph)
            P_FETCH: begin ev[9] = 1'b1; ev[8] = imem_ready; end
            P_EXEC:  ev[7] = 1'b1;
            P_MEM:   begin ev[6] = 1'b1; ev[5] = is_store; end
            P_WB:    begin ev[3] = 1'b1; ev[4] = writes_reg & ~m_resumed; ev[2] = branch_taken & ~m_resumed; end
            P_HALT:  ev[1] = 1'b1;
            P_FAULT: ev[0] = 1'b1;
            default: ;
        endcase
        av = {state, imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault};
        check("model_outputs", 64'(av), 64'(ev));
        check("model_cycle_count", 64'(cycle_count), 64'(m_cyc));
        check("model_instr_count", 64'(instr_count), 64'(m_ins));
        if (rst_n) begin
            nxt = m_ph;
            case (m_ph)
                P_BOOT: nxt = P_FETCH;
                P_FETCH, P_MEM: begin
                    rdy = (m_ph == P_FETCH) ? imem_ready : dmem_ready;
                    if (rdy) nxt = (m_ph == P_FETCH) ? P_DECODE : P_WB;
                    else if (m_stall + 1 == int'(T)) nxt = P_FAULT;
                    else m_stall++;
                end
                P_DECODE: nxt = is_halt ? P_HALT : P_EXEC;
                P_EXEC:   nxt = is_mem ? P_MEM : P_WB;
                P_WB: begin nxt = P_FETCH; m_ins++; m_resumed = 1'b0; end
                P_HALT: if (m_hist[2] && !m_hist[3]) begin nxt = P_WB; m_resumed = 1'b1; end
                default: ;
            endcase
            if (nxt != m_ph) m_stall = 0;
            m_ph = nxt;
            m_cyc++;
            m_hist = {m_hist[2:0], cont};
        end
    end

    task automatic run_alu(input logic exp_sel);
        check("alu_fetch_state", 64'(state), 64'(1));
        step();
        step();
        check("alu_exec_pc_sel", 64'(pc_sel), 64'(0));
        step();
        check("alu_wb_state", 64'(state), 64'(5));
        check("alu_wb_pc_sel", 64'(pc_sel), 64'(exp_sel));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, ic, npc, nrf, nmem;
        bit saw_halt;
        writes_reg = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(state), 64'(0));
        check("reset_outputs", 64'({imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, fault}), 64'(0));
        check("reset_cycle", 64'(cycle_count), 64'(0));

        // Three zero-wait ALU instructions
        rst_n = 1'b1;
        #1;
        npc = 0; nrf = 0;
        for (int e = 0; e < 13; e++) begin
            if (e < 6) check("t1_state_seq", 64'(state), 64'(seq1[e]));
            npc += int'(pc_en);
            nrf += int'(rf_we);
            step();
        end
        check("t1_instr_count", 64'(instr_count), 64'(3));
        check("t1_cycle_count", 64'(cycle_count), 64'(13));
        check("t1_pc_en_count", 64'(npc), 64'(3));
        check("t1_rf_we_count", 64'(nrf), 64'(3));

        // Load with stalled instruction and data memories
        is_mem = 1'b1; is_store = 1'b0;
        c0 = int'(cycle_count);
        for (int i = 0; i < 5; i++) begin
            imem_ready = (i == 4);
            #1;
            check("t2_imem_req", 64'(imem_req), 64'(1));
            check("t2_ir_en", 64'(ir_en), 64'(i == 4));
            step();
        end
        check("t2_decode", 64'(state), 64'(2));
        step();
        check("t2_alu_en", 64'(alu_en), 64'(1));
        step();
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 2);
            #1;
            check("t2_dmem_req_we", 64'({dmem_req, dmem_we}), 64'(2'b10));
            step();
        end
        check("t2_wb", 64'({state, pc_en, rf_we}), 64'({3'd5, 2'b11}));
        step();
        check("t2_latency", 64'(int'(cycle_count) - c0), 64'(11));
        check("t2_fault", 64'(fault), 64'(0));

        // Taken and not-taken branches
        is_mem = 1'b0;
        branch_taken = 1'b1;
        run_alu(1'b1);
        branch_taken = 1'b0;
        run_alu(1'b0);

        // HALT then resume on continue
        is_halt = 1'b1; branch_taken = 1'b1;
        step();
        step();
        check("t3_halt_state", 64'(state), 64'(6));
        for (int i = 0; i < 50; i++) begin
            check("t3_halted_pc_en", 64'({halted, pc_en}), 64'(2'b10));
            step();
        end
        ic = int'(instr_count);
        cont = 1'b1;
        step(); step(); step();
        check("t3_still_halted", 64'(state), 64'(6));
        step();
        check("t3_resume_wb", 64'({state, pc_en, pc_sel, rf_we}), 64'({3'd5, 3'b100}));
        is_halt = 1'b0; branch_taken = 1'b0;
        step();
        check("t3_after_wb", 64'(state), 64'(1));
        check("t3_halt_retired", 64'(instr_count), 64'(ic + 1));
        repeat (5) step();
        cont = 1'b0;
        repeat (4) step();
        cont = 1'b1;
        saw_halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) cont = 1'b0;
            if (state == 3'd6) saw_halt = 1'b1;
            step();
        end
        check("t3_pulse_ignored", 64'(saw_halt), 64'(0));

        // Reset in the middle of a data-memory wait
        for (int i = 0; i < 10 && state != 3'd1; i++) step();
        check("t6_at_fetch", 64'(state), 64'(1));
        is_mem = 1'b1; dmem_ready = 1'b0;
        step(); step(); step();
        check("t6_in_mem", 64'({state, dmem_req}), 64'({3'd4, 1'b1}));
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", 64'({state, dmem_req}), 64'(0));
        check("t6_counters", 64'({cycle_count, instr_count}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("t6_resume_fetch", 64'(state), 64'(1));

        // Data memory never answers
        step(); step(); step();
        nmem = 0;
        for (int i = 0; i < 40 && state == 3'd4; i++) begin
            nmem++;
            step();
        end
        check("t4_wait_cycles", 64'(nmem), 64'(T));
        check("t4_fault_state", 64'({state, fault}), 64'({3'd7, 1'b1}));
        check("t4_enables_off", 64'({imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en}), 64'(0));
        repeat (20) step();
        check("t4_sticky", 64'({state, fault}), 64'({3'd7, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("t4_reset_clears", 64'({state, fault}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
